gpio_access_arbiter: RTL and testbench

//  Shares the single GPIO output register between NREQ bus masters (CPU store path, debug port, ...).

---
 rtl/gpio_access_arbiter_pkg.sv | 13 +
 rtl/gpio_access_arbiter_rr_arbiter.sv | 30 +++
 rtl/gpio_access_arbiter.sv | 138 +++++++++++++
 tb/tb_gpio_access_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_access_arbiter_pkg.sv
// Shared constants and FSM state encoding for the GPIO access arbiter.
package gpio_access_arbiter_pkg;

  localparam logic [31:0] GPIO_ADDR_DEFAULT = 32'd1024;
  localparam logic [7:0]  ERR_CNT_MAX       = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/gpio_access_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer wins.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  logic [IDW-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = IDW'((int'(i_ptr) + k) % NREQ);
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_access_arbiter.sv
// Round-robin arbiter sharing the GPIO output register between NREQ masters:
// accept -> one-cycle issue -> held response, with a saturating decode-error counter.
module gpio_access_arbiter
  import gpio_access_arbiter_pkg::*;
#(
  parameter int          NREQ      = 2,
  parameter int          IDW       = (NREQ > 2) ? $clog2(NREQ) : 1,
  parameter logic [31:0] GPIO_ADDR = GPIO_ADDR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*32-1:0] req_addr,
  input  logic [NREQ*32-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [IDW-1:0]     resp_id,
  output logic               resp_err,
  output logic [31:0]        resp_rdata,
  output logic               gpio_we,
  output logic [31:0]        gpio_addr,
  output logic [31:0]        gpio_wdata,
  input  logic [31:0]        gpio_rdata,
  output logic [7:0]         err_cnt
);

  state_t          r_state;
  state_t          w_nextState;
  logic [IDW-1:0]  r_rrPtr;
  logic [IDW-1:0]  r_id;
  logic            r_we;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic            r_respErr;
  logic [31:0]     r_respRdata;
  logic [7:0]      r_errCnt;
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_grantIdx;
  logic            w_anyReq;
  logic            w_hit;
  logic [IDW-1:0]  w_nextPtr;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rrArbiter (
    .i_req   (req_valid),
    .i_ptr   (r_rrPtr),
    .o_grant (w_grant),
    .o_idx   (w_grantIdx),
    .o_any   (w_anyReq)
  );

  assign w_hit     = (r_addr == GPIO_ADDR);
  assign w_nextPtr = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + IDW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Grants and the write strobe are decoded straight from state so they never lag a cycle.
  always_comb begin
    w_nextState = r_state;
    req_ready   = '0;
    gpio_we     = 1'b0;
    resp_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_anyReq) begin
          req_ready   = w_grant;
          w_nextState = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        gpio_we     = w_hit && r_we;
        w_nextState = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rrPtr     <= '0;
      r_id        <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_respErr   <= 1'b0;
      r_respRdata <= '0;
      r_errCnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_anyReq) begin
            r_id    <= w_grantIdx;
            r_we    <= req_we[w_grantIdx];
            r_addr  <= req_addr[w_grantIdx*32 +: 32];
            r_wdata <= req_wdata[w_grantIdx*32 +: 32];
          end
        end
        ST_ISSUE: begin
          r_respErr   <= !w_hit;
          r_respRdata <= (w_hit && !r_we) ? gpio_rdata : '0;
          if (!w_hit && (r_errCnt != ERR_CNT_MAX)) begin
            r_errCnt <= r_errCnt + 8'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_rrPtr <= w_nextPtr;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_id    = r_id;
  assign resp_err   = r_respErr;
  assign resp_rdata = r_respRdata;
  assign gpio_addr  = r_addr;
  assign gpio_wdata = r_wdata;
  assign err_cnt    = r_errCnt;

endmodule

// File: tb/tb_gpio_access_arbiter.sv
// Directed scoreboard bench for gpio_access_arbiter with a behavioural GPIO register.
module tb_gpio_access_arbiter;

  localparam int          NREQ  = 2;
  localparam logic [31:0] GADDR = 32'd1024;
  localparam logic [31:0] BADDR = 32'd1028;

  typedef struct {
    logic [0:0]  id;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    reqValid;
  logic [NREQ-1:0]    reqWe;
  logic [NREQ*32-1:0] reqAddr;
  logic [NREQ*32-1:0] reqWdata;
  logic [NREQ-1:0]    reqReady;
  logic               respValid;
  logic               respReady;
  logic [0:0]         respId;
  logic               respErr;
  logic [31:0]        respRdata;
  logic               gpioWe;
  logic [31:0]        gpioAddr;
  logic [31:0]        gpioWdata;
  logic [31:0]        gpioRdata;
  logic [7:0]         errCnt;

  logic [31:0] gpioReg = 32'd0;
  logic [31:0] gpioModel = 32'd0;
  logic [7:0]  errModel = 8'd0;
  exp_t        sbQ[$];
  exp_t        monExp;
  int          nTotal = 0;
  int          nPass = 0;
  int          nFail = 0;

  always #5 clk = ~clk;

  gpio_access_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (reqValid),
    .req_we     (reqWe),
    .req_addr   (reqAddr),
    .req_wdata  (reqWdata),
    .req_ready  (reqReady),
    .resp_valid (respValid),
    .resp_ready (respReady),
    .resp_id    (respId),
    .resp_err   (respErr),
    .resp_rdata (respRdata),
    .gpio_we    (gpioWe),
    .gpio_addr  (gpioAddr),
    .gpio_wdata (gpioWdata),
    .gpio_rdata (gpioRdata),
    .err_cnt    (errCnt)
  );

  // The GPIO register the arbiter fronts; written on the strobe, read back combinationally.
  always @(posedge clk) if (gpioWe) gpioReg <= gpioWdata;
  assign gpioRdata = gpioReg;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTotal = nTotal + 1;
    assert (obs === exp) nPass = nPass + 1;
    else begin
      nFail = nFail + 1;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pushExpect(input int m, input logic we, input logic [31:0] addr);
    exp_t e;
    e.id    = 1'(m);
    e.err   = (addr != GADDR);
    e.rdata = (!e.err && !we) ? gpioModel : 32'd0;
    sbQ.push_back(e);
    if (e.err && errModel != 8'd255) errModel = errModel + 8'd1;
  endtask

  // Presents one request, waits for its grant, then checks the issue cycle.
  task automatic applyStimulus(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    logic got;
    logic expWe;
    reqValid[m] = 1'b1;
    reqWe[m] = we;
    reqAddr[32*m +: 32] = addr;
    reqWdata[32*m +: 32] = wdata;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = reqReady[m];
    end
    checkOutput("acceptSeen", {31'b0, got}, 32'd1);
    if (!got) begin
      reqValid[m] = 1'b0;
      return;
    end
    pushExpect(m, we, addr);
    @(posedge clk);
    #1 reqValid[m] = 1'b0;
    @(negedge clk);
    expWe = (addr == GADDR) && we;
    checkOutput("issueGpioWe", {31'b0, gpioWe}, {31'b0, expWe});
    if (expWe) begin
      checkOutput("issueWdata", gpioWdata, wdata);
      checkOutput("issueAddr", gpioAddr, addr);
      gpioModel = wdata;
    end
  endtask

  task automatic finishOp();
    @(negedge clk);
    checkOutput("respValid", {31'b0, respValid}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && respValid && respReady) begin
      if (sbQ.size() == 0) begin
        checkOutput("sbUnexpectedResp", {31'b0, respValid}, 32'd0);
      end else begin
        monExp = sbQ.pop_front();
        checkOutput("respId", {31'b0, respId}, {31'b0, monExp.id});
        checkOutput("respErr", {31'b0, respErr}, {31'b0, monExp.err});
        checkOutput("respRdata", respRdata, monExp.rdata);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic got;
    int   expM;
    rst_n = 1'b0;
    reqValid = '0;
    reqWe = '0;
    reqAddr = '0;
    reqWdata = '0;
    respReady = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rstRespValid", {31'b0, respValid}, 32'd0);
    checkOutput("rstGpioWe", {31'b0, gpioWe}, 32'd0);
    checkOutput("rstErrCnt", {24'b0, errCnt}, 32'd0);
    checkOutput("rstRespRdata", respRdata, 32'd0);
    @(posedge clk);
    #1;

    // Bump the error counter so reset clearing it is visible.
    applyStimulus(0, 1'b1, BADDR, 32'h0000_0001);
    finishOp();
    checkOutput("errCntOne", {24'b0, errCnt}, {24'b0, errModel});

    // Reset lands while a write is in its issue cycle.
    reqValid[0] = 1'b1;
    reqWe[0] = 1'b1;
    reqAddr[31:0] = GADDR;
    reqWdata[31:0] = 32'h0BAD_F00D;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = reqReady[0];
    end
    checkOutput("rstAcceptSeen", {31'b0, got}, 32'd1);
    @(posedge clk);
    #1 reqValid[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midIssueWe", {31'b0, gpioWe}, 32'd1);
    gpioModel = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    checkOutput("postRstGpioWe", {31'b0, gpioWe}, 32'd0);
    checkOutput("postRstRespValid", {31'b0, respValid}, 32'd0);
    checkOutput("postRstErrCnt", {24'b0, errCnt}, 32'd0);
    checkOutput("postRstReqReady", {30'b0, reqReady}, 32'd0);
    errModel = 8'd0;
    sbQ.delete();
    rst_n = 1'b1;

    // Single write from master 0, then read-back from master 1.
    applyStimulus(0, 1'b1, GADDR, 32'hA5A5_0001);
    finishOp();
    applyStimulus(1, 1'b0, GADDR, 32'd0);
    finishOp();

    // Contention: both held valid, expect strict alternation starting at master 0.
    reqValid = 2'b11;
    reqWe = 2'b10;
    reqAddr = {BADDR, GADDR};
    reqWdata = {32'h0000_00C1, 32'h0};
    for (int k = 0; k < 4; k++) begin
      expM = k % 2;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        got = |reqReady;
      end
      checkOutput("contendGrant", {30'b0, reqReady}, 32'(1 << expM));
      pushExpect(expM, reqWe[expM], reqAddr[32*expM +: 32]);
      @(posedge clk);
    end
    #1 reqValid = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("contendDrained", 32'(sbQ.size()), 32'd0);
    checkOutput("errCntContend", {24'b0, errCnt}, {24'b0, errModel});

    // Decode errors until the counter pins at its maximum.
    for (int k = 0; k < 300; k++) begin
      applyStimulus(0, 1'b1, BADDR, 32'(k));
      finishOp();
    end
    checkOutput("errCntSat", {24'b0, errCnt}, 32'd255);
    checkOutput("errModelSat", {24'b0, errCnt}, {24'b0, errModel});

    // Backpressure: response must hold and nothing else may proceed.
    respReady = 1'b0;
    applyStimulus(1, 1'b0, GADDR, 32'd0);
    reqValid[0] = 1'b1;
    reqWe[0] = 1'b1;
    reqAddr[31:0] = GADDR;
    reqWdata[31:0] = 32'h5A5A_0002;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bpRespValid", {31'b0, respValid}, 32'd1);
      checkOutput("bpRespId", {31'b0, respId}, 32'd1);
      checkOutput("bpRespRdata", respRdata, gpioModel);
      checkOutput("bpReqReady", {30'b0, reqReady}, 32'd0);
      checkOutput("bpGpioWe", {31'b0, gpioWe}, 32'd0);
    end
    @(posedge clk);
    #1 reqValid[0] = 1'b0;
    respReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bpDrained", 32'(sbQ.size()), 32'd0);

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
